// File: rtl/rs_syndrome_seq.sv
// Horner-rule syndrome sequencer for RS(31,k) over GF(2^5), p(x) = x^5 + x^2 + 1.
// Optional build macro RS_SYN_ZERO_SKIP_EN skips streaming when every syndrome is zero.
module rs_syndrome_seq #(
  parameter int NSYN = 4,
  parameter int NSYM = 31
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [4:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic [4:0] syn_out,
  output logic [2:0] syn_idx,
  output logic       syn_valid,
  input  logic       syn_ready,
  output logic       err_flag,
  output logic       block_done,
  output logic       busy
);

  typedef enum logic [1:0] {ACCEPT, UPDATE, OUTPUT, DONE} state_e;

  localparam int CNT_W = $clog2(NSYM + 1);
  localparam logic [CNT_W-1:0] NSYM_C = CNT_W'(NSYM);
  localparam logic [2:0] LAST_J = 3'(NSYN - 1);

  // alpha^1 .. alpha^8 in polynomial basis, MSB = x^4
  localparam logic [4:0] ALPHA [8] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000,
                                       5'b00101, 5'b01010, 5'b10100, 5'b01101};

  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] p;
    logic [4:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 5; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[3:0], 1'b0} ^ (t[4] ? 5'b00101 : 5'b00000);
    end
    return p;
  endfunction

  state_e           state_q, state_d;
  logic [4:0]       s_q [NSYN];
  logic [4:0]       s_d [NSYN];
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [2:0]       iter_q, iter_d;
  logic [2:0]       k_q, k_d;
  logic [4:0]       r_hold_q, r_hold_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             any_nz;

  // NOTE: every output and next-state signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    sym_cnt_d = sym_cnt_q;
    iter_d    = iter_q;
    k_d       = k_q;
    r_hold_d  = r_hold_q;
    err_d     = err_q;
    busy_d    = busy_q;
    any_nz    = 1'b0;

    sym_ready  = 1'b0;
    syn_valid  = 1'b0;
    syn_out    = '0;
    block_done = 1'b0;

    case (state_q)
      ACCEPT: begin
        sym_ready = 1'b1;
        if (sym_valid) begin
          r_hold_d  = sym_in;
          sym_cnt_d = sym_cnt_q + 1'b1;
          busy_d    = 1'b1;
          iter_d    = '0;
          if (sym_cnt_q == '0) err_d = 1'b0;
          state_d   = UPDATE;
        end
      end

      UPDATE: begin
        for (int i = 0; i < NSYN; i++) begin
          if (iter_q == 3'(i)) s_d[i] = gf_mul(s_q[i], ALPHA[i]) ^ r_hold_q;
        end
        if (iter_q == LAST_J) begin
          iter_d = '0;
          if (sym_cnt_q == NSYM_C) begin
            // Flag uses the post-update values so the final symbol's contribution counts.
            for (int i = 0; i < NSYN; i++) any_nz = any_nz | (|s_d[i]);
            err_d   = any_nz;
            state_d = OUTPUT;
`ifdef RS_SYN_ZERO_SKIP_EN
            if (!any_nz) begin
              busy_d  = 1'b0;
              state_d = DONE;
            end
`else
`endif
          end else begin
            state_d = ACCEPT;
          end
        end else begin
          iter_d = iter_q + 3'd1;
        end
      end

      OUTPUT: begin
        syn_valid = 1'b1;
        for (int i = 0; i < NSYN; i++) begin
          if (k_q == 3'(i)) syn_out = s_q[i];
        end
        if (syn_ready) begin
          if (k_q == LAST_J) begin
            k_d     = '0;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end

      DONE: begin
        block_done = 1'b1;
        for (int i = 0; i < NSYN; i++) s_d[i] = '0;
        sym_cnt_d = '0;
        k_d       = '0;
        state_d   = ACCEPT;
      end

      default: state_d = ACCEPT;
    endcase
  end

  assign syn_idx  = k_q;
  assign err_flag = err_q;
  assign busy     = busy_q;

  // NOTE: the syndrome bank is a handful of flops, not RAM, so it is cleared by reset along with the control state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ACCEPT;
      for (int i = 0; i < NSYN; i++) s_q[i] <= '0;
      sym_cnt_q <= '0;
      iter_q    <= '0;
      k_q       <= '0;
      r_hold_q  <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the same pre-edge values.
      state_q   <= state_d;
      for (int i = 0; i < NSYN; i++) s_q[i] <= s_d[i];
      sym_cnt_q <= sym_cnt_d;
      iter_q    <= iter_d;
      k_q       <= k_d;
      r_hold_q  <= r_hold_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_rs_syndrome_seq.sv
// Directed self-checking bench for rs_syndrome_seq (NSYN=4, NSYM=31).
// Expected syndromes are hand-derived powers of alpha in GF(2^5), p(x) = x^5 + x^2 + 1.
module tb_rs_syndrome_seq;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [4:0] sym_in;
  logic       sym_valid;
  logic       sym_ready;
  logic [4:0] syn_out;
  logic [2:0] syn_idx;
  logic       syn_valid;
  logic       syn_ready;
  logic       err_flag;
  logic       block_done;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  rs_syndrome_seq #(.NSYN(4), .NSYM(31)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .syn_out    (syn_out),
    .syn_idx    (syn_idx),
    .syn_valid  (syn_valid),
    .syn_ready  (syn_ready),
    .err_flag   (err_flag),
    .block_done (block_done),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the symbol was consumed.
  task automatic send_sym(input logic [4:0] s);
    int n;
    n = 0;
    sym_in    = s;
    sym_valid = 1'b1;
    while (!sym_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("sym_ready_wait", {31'd0, sym_ready}, 32'd1);
    @(negedge clock);
    sym_valid = 1'b0;
  endtask

  task automatic expect_block(input string tag,
                              input logic [4:0] e0, input logic [4:0] e1,
                              input logic [4:0] e2, input logic [4:0] e3,
                              input logic err_exp, input int stall_k);
    logic [4:0] e [4];
    int n;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    n = 0;
    while (!syn_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    check($sformatf("%s_syn_valid_wait", tag), {31'd0, syn_valid}, 32'd1);
    check($sformatf("%s_err_flag", tag), {31'd0, err_flag}, {31'd0, err_exp});
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_idx%0d", tag, k), {29'd0, syn_idx}, k);
      check($sformatf("%s_syn%0d", tag, k), {27'd0, syn_out}, {27'd0, e[k]});
      if (k == stall_k) begin
        syn_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clock);
          check($sformatf("%s_stall_idx_c%0d", tag, c), {29'd0, syn_idx}, k);
          check($sformatf("%s_stall_syn_c%0d", tag, c), {27'd0, syn_out}, {27'd0, e[k]});
          check($sformatf("%s_stall_valid_c%0d", tag, c), {31'd0, syn_valid}, 32'd1);
        end
        syn_ready = 1'b1;
      end
      @(negedge clock);
    end
    check($sformatf("%s_block_done", tag), {31'd0, block_done}, 32'd1);
    check($sformatf("%s_busy_done", tag), {31'd0, busy}, 32'd0);
    check($sformatf("%s_valid_done", tag), {31'd0, syn_valid}, 32'd0);
    check($sformatf("%s_err_done", tag), {31'd0, err_flag}, {31'd0, err_exp});
    @(negedge clock);
    check($sformatf("%s_done_pulse_end", tag), {31'd0, block_done}, 32'd0);
    check($sformatf("%s_ready_after", tag), {31'd0, sym_ready}, 32'd1);
  endtask

  initial begin
    int cnt;
    int last;
    int gap_bad;
    int seen_valid;
    int n;

    reset_n   = 1'b0;
    sym_in    = '0;
    sym_valid = 1'b0;
    syn_ready = 1'b1;

    #1;
    check("rst_sym_ready", {31'd0, sym_ready}, 32'd1);
    check("rst_syn_valid", {31'd0, syn_valid}, 32'd0);
    check("rst_syn_out", {27'd0, syn_out}, 32'd0);
    check("rst_syn_idx", {29'd0, syn_idx}, 32'd0);
    check("rst_err_flag", {31'd0, err_flag}, 32'd0);
    check("rst_block_done", {31'd0, block_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Block 1: all-zero codeword
    send_sym(5'd0);
    check("zero_busy_first", {31'd0, busy}, 32'd1);
    for (int i = 1; i < 31; i++) send_sym(5'd0);
`ifdef RS_SYN_ZERO_SKIP_EN
    seen_valid = 0;
    n = 0;
    while (!block_done && n < 20) begin
      if (syn_valid) seen_valid++;
      @(negedge clock);
      n++;
    end
    check("zskip_no_valid", seen_valid, 32'd0);
    check("zskip_block_done", {31'd0, block_done}, 32'd1);
    check("zskip_busy", {31'd0, busy}, 32'd0);
    check("zskip_err", {31'd0, err_flag}, 32'd0);
    @(negedge clock);
    check("zskip_done_end", {31'd0, block_done}, 32'd0);
`else
    expect_block("zero", 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, -1);
`endif

    // Block 2: r_0 = 1 only -> every syndrome is 1
    for (int i = 0; i < 30; i++) send_sym(5'd0);
    send_sym(5'b00001);
    expect_block("r0", 5'b00001, 5'b00001, 5'b00001, 5'b00001, 1'b1, -1);

    // Block 3: r_30 = 1 only -> S_j = alpha^-j; stall consumer at idx 1
    send_sym(5'b00001);
    check("err_clear_first_sym", {31'd0, err_flag}, 32'd0);
    for (int i = 0; i < 30; i++) send_sym(5'd0);
    expect_block("r30", 5'b10010, 5'b01001, 5'b10110, 5'b01011, 1'b1, 1);

    // Block 4: sym_valid held high; r_0 = 3 -> every syndrome is 3
    cnt       = 0;
    last      = -1;
    gap_bad   = 0;
    sym_valid = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (syn_valid) break;
      sym_in = (cnt == 30) ? 5'b00011 : 5'b00000;
      if (sym_ready) begin
        cnt++;
        if (last >= 0 && cyc - last != 5) gap_bad++;
        last = cyc;
      end
      @(negedge clock);
    end
    sym_valid = 1'b0;
    check("cont_sym_count", cnt, 32'd31);
    check("cont_ready_gap", gap_bad, 32'd0);
    expect_block("cont", 5'b00011, 5'b00011, 5'b00011, 5'b00011, 1'b1, -1);

    // Reset in the middle of a block
    for (int i = 0; i < 10; i++) send_sym(5'b00001);
    check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_sym_ready", {31'd0, sym_ready}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_err_flag", {31'd0, err_flag}, 32'd0);
    check("mid_rst_syn_valid", {31'd0, syn_valid}, 32'd0);
    check("mid_rst_syn_idx", {29'd0, syn_idx}, 32'd0);
    check("mid_rst_block_done", {31'd0, block_done}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Clean block after reset: r_30 = r_0 = 1 -> S_j = alpha^-j + 1
    send_sym(5'b00001);
    for (int i = 0; i < 29; i++) send_sym(5'd0);
    send_sym(5'b00001);
    expect_block("post_rst", 5'b10011, 5'b01000, 5'b10111, 5'b01010, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
